bit_sync_filt: RTL and testbench

Multi-bit, multi-stage level synchronizer with a per-channel stability filter and registered rise/fall pulse outputs. It brings independent asynchronous single-bit signals (strobes, switches, status lines) into the CLK domain. It rejects any synchronized level that is not stable for FILTER_LEN cycles and flags each accepted transition with a one-cycle pulse. It is the drop-in successor to the plain flop-chain bit synchronizer, for inputs that need glitch rejection and edge detection.

---
 rtl/bit_sync_filt_pkg.sv | 18 +
 rtl/bit_sync_filt_ch.sv | 59 +++++
 rtl/bit_sync_filt.sv | 40 ++++
 tb/tb_bit_sync_filt.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_sync_filt_pkg.sv
// Shared helpers for bit_sync_filt: filter counter width and parameter range checks.
// No types are exported; the channel and top import this for elaboration-time math.
package bit_sync_filt_pkg;

   // $clog2(1) is 0, so the counter is given a 1-bit floor.
   function automatic int unsigned cnt_width(input int unsigned filter_len);
      int unsigned w;
      w = $clog2(filter_len);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit params_ok(input int unsigned bus_width,
                                    input int unsigned num_stages,
                                    input int unsigned filter_len);
      return (bus_width >= 1) && (num_stages >= 2) && (filter_len >= 1);
   endfunction

endpackage

// File: rtl/bit_sync_filt_ch.sv
// One channel of bit_sync_filt: synchronizer chain, stability filter, and
// registered rise/fall pulses that coincide with the filtered level change.
module bit_sync_filt_ch
   import bit_sync_filt_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned FILTER_LEN = 3
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic async_bit,
   output logic sync_bit,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] chain;
   logic          raw;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[NUM_STAGES-2:0], async_bit};
      end
   end

   assign raw = chain[NUM_STAGES-1];

   // With FILTER_LEN=1 CNT_LAST is 0, so every mismatch is accepted at once
   // and the counter never leaves 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         sync_bit <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (raw == sync_bit) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            sync_bit <= raw;
            rise     <= raw;
            fall     <= ~raw;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bit_sync_filt.sv
// Multi-bit level synchronizer with per-channel stability filter and edge pulses.
// Channels are independent; ANY_EDGE is a plain OR of the registered pulses.
module bit_sync_filt
   import bit_sync_filt_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = 2,
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned FILTER_LEN = 3
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] ASYNC,
   output logic [BUS_WIDTH-1:0] SYNC,
   output logic [BUS_WIDTH-1:0] RISE,
   output logic [BUS_WIDTH-1:0] FALL,
   output logic                 ANY_EDGE
);

   if (!params_ok(BUS_WIDTH, NUM_STAGES, FILTER_LEN)) begin : g_param_err
      $error("bit_sync_filt: BUS_WIDTH>=1, NUM_STAGES>=2, FILTER_LEN>=1 required");
   end

   for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_ch
      bit_sync_filt_ch #(
         .NUM_STAGES (NUM_STAGES),
         .FILTER_LEN (FILTER_LEN)
      ) u_ch (
         .clk       (CLK),
         .rst_n     (RST),
         .async_bit (ASYNC[g]),
         .sync_bit  (SYNC[g]),
         .rise      (RISE[g]),
         .fall      (FALL[g])
      );
   end

   assign ANY_EDGE = |(RISE | FALL);

endmodule

// File: tb/tb_bit_sync_filt.sv
// Bench for bit_sync_filt: three parameterisations share one stimulus stream and
// are compared each cycle against a sliding-window model, plus directed latency checks.
module tb_bit_sync_filt;

   localparam int NI = 3;
   localparam int NS_T [NI] = '{2, 2, 3};
   localparam int FL_T [NI] = '{3, 1, 4};

   logic       CLK;
   logic       RST;
   logic [1:0] ASYNC;
   logic [1:0] sync_o [NI];
   logic [1:0] rise_o [NI];
   logic [1:0] fall_o [NI];
   logic       any_o  [NI];

   int n_chk  = 0;
   int n_fail = 0;

   bit_sync_filt #(.BUS_WIDTH(2), .NUM_STAGES(2), .FILTER_LEN(3)) dut (
      .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
      .SYNC(sync_o[0]), .RISE(rise_o[0]), .FALL(fall_o[0]), .ANY_EDGE(any_o[0]));

   bit_sync_filt #(.BUS_WIDTH(2), .NUM_STAGES(2), .FILTER_LEN(1)) dut_f1 (
      .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
      .SYNC(sync_o[1]), .RISE(rise_o[1]), .FALL(fall_o[1]), .ANY_EDGE(any_o[1]));

   bit_sync_filt #(.BUS_WIDTH(2), .NUM_STAGES(3), .FILTER_LEN(4)) dut_s3f4 (
      .CLK(CLK), .RST(RST), .ASYNC(ASYNC),
      .SYNC(sync_o[2]), .RISE(rise_o[2]), .FALL(fall_o[2]), .ANY_EDGE(any_o[2]));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: history of ASYNC samples per edge; a level is accepted once
   // the last FILTER_LEN synchronized samples all disagree with the current output.
   bit [31:0] hist   [NI][2];
   bit        m_sync [NI][2];
   bit        m_rise [NI][2];
   bit        m_fall [NI][2];
   bit        win;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NI; i++)
            for (int c = 0; c < 2; c++) begin
               hist[i][c]   = '0;
               m_sync[i][c] = 1'b0;
               m_rise[i][c] = 1'b0;
               m_fall[i][c] = 1'b0;
            end
      end else begin
         for (int i = 0; i < NI; i++)
            for (int c = 0; c < 2; c++) begin
               win = 1'b1;
               for (int j = NS_T[i] - 1; j <= NS_T[i] + FL_T[i] - 2; j++)
                  if (hist[i][c][j] == m_sync[i][c]) win = 1'b0;
               m_rise[i][c] = win && !m_sync[i][c];
               m_fall[i][c] = win &&  m_sync[i][c];
               if (win) m_sync[i][c] = !m_sync[i][c];
               hist[i][c] = {hist[i][c][30:0], ASYNC[c]};
            end
      end
   end

   always @(negedge CLK) begin
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("model_sync_i%0d", i), sync_o[i], {m_sync[i][1], m_sync[i][0]});
         chk($sformatf("model_rise_i%0d", i), rise_o[i], {m_rise[i][1], m_rise[i][0]});
         chk($sformatf("model_fall_i%0d", i), fall_o[i], {m_fall[i][1], m_fall[i][0]});
         chk($sformatf("model_any_i%0d", i), any_o[i],
             m_rise[i][0] | m_rise[i][1] | m_fall[i][0] | m_fall[i][1]);
      end
   end

   task automatic to_drive();
      @(posedge CLK);
      #2;
   endtask

   // Called right after ASYNC (or RST release) changed, just past an edge.
   task automatic lat_check(input string tag, input logic [1:0] mask, input logic val);
      logic [1:0] s_exp, p_exp;
      int lat;
      for (int e = 1; e <= 9; e++) begin
         @(posedge CLK);
         @(negedge CLK);
         for (int i = 0; i < NI; i++) begin
            lat   = NS_T[i] + FL_T[i];
            s_exp = ((e >= lat) == val) ? mask : 2'b00;
            p_exp = (e == lat) ? mask : 2'b00;
            chk($sformatf("%s_sync_i%0d_e%0d", tag, i, e), sync_o[i] & mask, s_exp);
            chk($sformatf("%s_rise_i%0d_e%0d", tag, i, e), rise_o[i] & mask, val ? p_exp : 2'b00);
            chk($sformatf("%s_fall_i%0d_e%0d", tag, i, e), fall_o[i] & mask, val ? 2'b00 : p_exp);
            chk($sformatf("%s_any_i%0d_e%0d", tag, i, e), any_o[i], e == lat);
         end
      end
   endtask

   initial begin
      RST   = 1'b1;
      ASYNC = 2'b00;
      #1 RST = 1'b0;
      ASYNC = 2'b11;

      // Reset with inputs high: everything stays 0, then both channels rise together.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_sync", sync_o[0], 2'b00);
      chk("rst_rise", rise_o[0], 2'b00);
      chk("rst_fall", fall_o[0], 2'b00);
      chk("rst_any", any_o[0], 1'b0);
      to_drive();
      RST = 1'b1;
      lat_check("rst_rel", 2'b11, 1'b1);

      to_drive();
      ASYNC = 2'b00;
      repeat (12) @(posedge CLK);
      #2;

      // Level step on channel 0, both directions, across all three parameter sets.
      ASYNC = 2'b01;
      lat_check("step_up", 2'b01, 1'b1);
      to_drive();
      ASYNC = 2'b00;
      lat_check("step_dn", 2'b01, 1'b0);

      // Glitches on channel 1: one sampled edge, then two sampled edges.
      to_drive();
      ASYNC = 2'b10;
      to_drive();
      ASYNC = 2'b00;
      for (int e = 0; e < 10; e++) begin
         @(negedge CLK);
         chk("glitch1_sync", sync_o[0][1], 1'b0);
         chk("glitch1_edge", rise_o[0][1] | fall_o[0][1], 1'b0);
      end
      to_drive();
      ASYNC = 2'b10;
      repeat (2) @(posedge CLK);
      #2;
      ASYNC = 2'b00;
      for (int e = 0; e < 10; e++) begin
         @(negedge CLK);
         chk("glitch2_sync", sync_o[0][1], 1'b0);
         chk("glitch2_edge", rise_o[0][1] | fall_o[0][1], 1'b0);
      end

      // Independent channels: ch1 rises, ch0 two edges later.
      repeat (6) @(posedge CLK);
      #2;
      ASYNC = 2'b10;
      repeat (2) @(posedge CLK);
      #2;
      ASYNC = 2'b11;
      for (int e = 1; e <= 9; e++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk($sformatf("indep_rise_e%0d", e), rise_o[0],
             (e == 3) ? 2'b10 : (e == 5) ? 2'b01 : 2'b00);
         chk($sformatf("indep_any_e%0d", e), any_o[0], (e == 3) || (e == 5));
      end

      to_drive();
      ASYNC = 2'b00;
      repeat (12) @(posedge CLK);
      #2;

      // Reset in the middle of filtering: no pulse, full latency after release.
      ASYNC = 2'b01;
      repeat (2) @(posedge CLK);
      #2;
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_sync", sync_o[0], 2'b00);
      chk("midrst_rise", rise_o[0], 2'b00);
      to_drive();
      RST = 1'b1;
      lat_check("midrst_rel", 2'b01, 1'b1);

      // Random levels with random hold times and occasional reset pulses.
      for (int n = 0; n < 300; n++) begin
         to_drive();
         ASYNC = 2'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            RST = 1'b0;
            #3;
            RST = 1'b1;
         end
         repeat ($urandom_range(0, 5)) @(posedge CLK);
      end

      repeat (12) @(posedge CLK);
      @(negedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
